// File: rtl/atf_mux_pkg.sv
// Shared types and helpers for the atf1502 pin-mux routing models.
// State encoding, guard counter width and select-width helper.
package atf_mux_pkg;

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_GUARD = 2'd1,
    ST_CONN  = 2'd2
  } bbm_state_t;

  localparam int GUARD_CNT_W = 4;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chan_demux_bbm_guard_timer.sv
// bbm_guard_timer: loadable saturating down-counter for break-before-make.
// Load restarts the count; done is high while the count sits at zero.
module bbm_guard_timer
  import atf_mux_pkg::*;
#(
  parameter int W = GUARD_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  input  logic         clr,
  output logic         done
);

  logic [W-1:0] cnt;

  // Saturates at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/chan_demux_bbm.sv
// chan_demux_bbm: routes one signal to one of CHANNELS registered outputs.
// Define CHAN_DEMUX_HOLD_EN to make released channels hold their last value.
module chan_demux_bbm
  import atf_mux_pkg::*;
#(
  parameter int                  CHANNELS = 4,
  parameter int                  SEL_W    = clog2_min1(CHANNELS),
  parameter int                  GUARD    = 2,
  parameter logic [CHANNELS-1:0] DEFAULT  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  input  logic                signal,
  output logic [CHANNELS-1:0] q,
  output logic [SEL_W-1:0]    active,
  output logic                connected,
  output logic                busy,
  output logic                sel_err
);

  localparam logic [SEL_W:0] CH_LIM =
    (SEL_W + 1)'(CHANNELS);
  localparam logic [GUARD_CNT_W-1:0] GLOAD =
    GUARD_CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam bit FAST = (GUARD == 0);

  bbm_state_t          state;
  bbm_state_t          state_n;
  logic [SEL_W-1:0]    target;
  logic [SEL_W-1:0]    tgt_n;
  logic [SEL_W-1:0]    act_n;
  logic [CHANNELS-1:0] q_n;
  logic                busy_n;
  logic                conn_n;
  logic                err_n;
  logic                sel_ok;
  logic                req;
  logic                t_load;
  logic                t_dec;
  logic                t_clr;
  logic                t_done;

  assign sel_ok = ({1'b0, sel} < CH_LIM);
  assign req    = en && sel_ok;

  bbm_guard_timer #(
    .W(GUARD_CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (t_load),
    .val  (GLOAD),
    .dec  (t_dec),
    .clr  (t_clr),
    .done (t_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PARK;
      target    <= '0;
      active    <= '0;
      q         <= DEFAULT;
      busy      <= 1'b0;
      connected <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= tgt_n;
      active    <= act_n;
      q         <= q_n;
      busy      <= busy_n;
      connected <= conn_n;
      sel_err   <= err_n;
    end
  end

  // Invalid selects never reach here as requests; the guard keeps counting.
  always_comb begin
    state_n = state;
    tgt_n   = target;
    act_n   = active;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_clr   = 1'b0;
    unique case (state)
      ST_PARK: begin
        if (req) begin
          if (FAST) begin
            state_n = ST_CONN;
            act_n   = sel;
          end else begin
            state_n = ST_GUARD;
            tgt_n   = sel;
            t_load  = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (!en) begin
          state_n = ST_PARK;
          t_clr   = 1'b1;
        end else if (req && (sel != target)) begin
          tgt_n  = sel;
          t_load = 1'b1;
        end else if (t_done) begin
          state_n = ST_CONN;
          act_n   = target;
        end else begin
          t_dec = 1'b1;
        end
      end
      ST_CONN: begin
        if (!en) begin
          state_n = ST_PARK;
        end else if (req && (sel != active)) begin
          if (FAST) begin
            act_n = sel;
          end else begin
            state_n = ST_GUARD;
            tgt_n   = sel;
            t_load  = 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_PARK;
        t_clr   = 1'b1;
      end
    endcase
  end

  always_comb begin
`ifdef CHAN_DEMUX_HOLD_EN
    // q itself is the hold register: released bits keep their last value.
    q_n = q;
`else
    q_n = DEFAULT;
`endif
    if (state_n == ST_CONN) q_n[act_n] = signal;
    busy_n = (state_n == ST_GUARD);
    conn_n = (state_n == ST_CONN);
    err_n  = en && !sel_ok;
  end

endmodule

// File: tb/tb_chan_demux_bbm.sv
// Randomised scoreboard bench for chan_demux_bbm.
// Two instances share stimulus: 4ch/guard 2 and 3ch/guard 0.
module tb_chan_demux_bbm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       signal = 1'b0;
  logic [1:0] sel = 2'd0;

  logic [3:0] qa;
  logic [1:0] acta;
  logic       cona, busya, erra;
  logic [2:0] qb;
  logic [1:0] actb;
  logic       conb, busyb, errb;

  chan_demux_bbm #(
    .CHANNELS(4), .GUARD(2), .DEFAULT(4'b1010)
  ) ua (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .signal(signal), .q(qa), .active(acta),
    .connected(cona), .busy(busya), .sel_err(erra)
  );

  chan_demux_bbm #(
    .CHANNELS(3), .GUARD(0), .DEFAULT(3'b101)
  ) ub (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .signal(signal), .q(qb), .active(actb),
    .connected(conb), .busy(busyb), .sel_err(errb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic [1:0] act;
    logic       conn;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;

  int         m_nch[2] = '{4, 3};
  int         m_g[2]   = '{2, 0};
  logic [3:0] m_def[2] = '{4'b1010, 4'b0101};
  bit         m_conn[2];
  bit         m_wait[2];
  int         m_act[2];
  int         m_tgt[2];
  int         m_left[2];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_conn[d] = 0;
      m_wait[d] = 0;
      m_act[d]  = 0;
      m_tgt[d]  = 0;
      m_left[d] = 0;
    end
  endfunction

  // Behaviour per clock: a pending connection waits out its park time.
  function automatic exp_t step(input int d, input bit e,
                                input int s, input bit sg);
    exp_t x;
    bit   ok;
    ok = (s < m_nch[d]);
    if (!e) begin
      m_conn[d] = 0;
      m_wait[d] = 0;
    end else if (ok && m_conn[d] && s == m_act[d]) begin
      m_conn[d] = 1;
    end else if (m_wait[d] && (!ok || s == m_tgt[d])) begin
      if (m_left[d] == 0) begin
        m_wait[d] = 0;
        m_conn[d] = 1;
        m_act[d]  = m_tgt[d];
      end else begin
        m_left[d] = m_left[d] - 1;
      end
    end else if (ok) begin
      if (m_g[d] == 0) begin
        m_conn[d] = 1;
        m_act[d]  = s;
      end else begin
        m_conn[d] = 0;
        m_wait[d] = 1;
        m_tgt[d]  = s;
        m_left[d] = m_g[d] - 1;
      end
    end
    x.q = m_def[d];
    if (m_conn[d]) x.q[m_act[d]] = sg;
    x.act  = 2'(m_act[d]);
    x.conn = m_conn[d];
    x.busy = m_wait[d];
    x.err  = e && !ok;
    return x;
  endfunction

  task automatic cyc(input bit e, input int s, input bit sg);
    en     = e;
    sel    = 2'(s);
    signal = sg;
    @(posedge clk);
    sb0.push_back(step(0, e, s, sg));
    sb1.push_back(step(1, e, s, sg));
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_qa"}, 32'(qa), 32'h1010 >> 12 & 0 | 32'b1010);
    chk({tag, "_qb"}, 32'(qb), 32'b101);
    chk({tag, "_cona"}, 32'(cona), 0);
    chk({tag, "_busya"}, 32'(busya), 0);
    chk({tag, "_conb"}, 32'(conb), 0);
    chk({tag, "_busyb"}, 32'(busyb), 0);
    chk({tag, "_erra"}, 32'(erra), 0);
    chk({tag, "_acta"}, 32'(acta), 0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check_reset("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb0.size() > 0) begin
      x = sb0.pop_front();
      chk("a_q", 32'(qa), 32'(x.q));
      chk("a_conn", 32'(cona), 32'(x.conn));
      chk("a_busy", 32'(busya), 32'(x.busy));
      chk("a_err", 32'(erra), 32'(x.err));
      if (x.conn) chk("a_act", 32'(acta), 32'(x.act));
    end
    if (sb1.size() > 0) begin
      x = sb1.pop_front();
      chk("b_q", 32'({1'b0, qb}), 32'(x.q));
      chk("b_conn", 32'(conb), 32'(x.conn));
      chk("b_busy", 32'(busyb), 32'(x.busy));
      chk("b_err", 32'(errb), 32'(x.err));
      if (x.conn) chk("b_act", 32'(actb), 32'(x.act));
    end
  end

  initial begin
    int s_cur;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);
    cyc(0, 0, 0);
    cyc(0, 2, 1);
    for (int i = 0; i < 6; i++) cyc(1, 2, 1'(i));
    for (int i = 0; i < 6; i++) cyc(1, 0, 1'(i + 1));
    for (int i = 0; i < 4; i++) cyc(1, 2, 1'(i));
    cyc(1, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 3, 1'(i));
    cyc(0, 3, 1);
    cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1'(i));
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 1);
    chk("pre_rst_conn", 32'(cona), 1);
    async_reset();
    s_cur = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) s_cur = int'($urandom_range(0, 3));
      cyc($urandom_range(0, 9) != 0, s_cur, 1'($urandom_range(0, 1)));
      if (i == 400) async_reset();
    end
    @(negedge clk);
    @(negedge clk);
    chk("sb0_drained", 32'(sb0.size()), 0);
    chk("sb1_drained", 32'(sb1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
